// File: rtl/xheep_fpga_status_ctrl.sv
// xheep_fpga_status_ctrl
//   Board-level status and input conditioning for X-HEEP FPGA wrappers.
//   Synchronises the board reset, conditions slow board inputs, latches the
//   first program exit and drives an LED bank (heartbeat / reset / pass / fail).
//
//   Optional feature macro: XHEEP_STATUS_DEBOUNCE_EN
//     defined     -> per-input debounce counters (DEBOUNCE_CYCLES stable cycles)
//     not defined -> debounced_o is the 2-flop synchronised raw_in_i
//
// Ports:
//   clk_gen        in   system clock
//   rst_n          in   board reset, asynchronous, active-low
//   rst_sync_no    out  synchronised reset for x_heep_system (async assert)
//   raw_in_i       in   [NUM_INPUTS] asynchronous board inputs
//   debounced_o    out  [NUM_INPUTS] conditioned inputs
//   exit_valid_i   in   exit valid (synchronous), rising edge captured
//   exit_value_i   in   [32] exit code
//   clear_i        in   synchronous clear of the latched exit
//   exit_latched_o out  an exit has been captured
//   exit_code_o    out  [32] captured exit code
//   led_o          out  [NUM_LEDS] LED drive (combinational mux of registers)

module xheep_fpga_status_ctrl #(
    parameter int NUM_LEDS        = 4,
    parameter int NUM_INPUTS      = 2,
    parameter int HB_COUNT_WIDTH  = 27,
    parameter int FAIL_BLINK_BIT  = 23,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk_gen,
    input  logic                  rst_n,
    output logic                  rst_sync_no,
    input  logic [NUM_INPUTS-1:0] raw_in_i,
    output logic [NUM_INPUTS-1:0] debounced_o,
    input  logic                  exit_valid_i,
    input  logic [31:0]           exit_value_i,
    input  logic                  clear_i,
    output logic                  exit_latched_o,
    output logic [31:0]           exit_code_o,
    output logic [NUM_LEDS-1:0]   led_o
);

    // Elaboration-time parameter sanity checks.
    if (NUM_LEDS < 2) begin : g_chk_leds
        $error("NUM_LEDS must be >= 2");
    end
    if (NUM_INPUTS < 1) begin : g_chk_inputs
        $error("NUM_INPUTS must be >= 1");
    end
    if (HB_COUNT_WIDTH < 2) begin : g_chk_hb
        $error("HB_COUNT_WIDTH must be >= 2");
    end
    if (FAIL_BLINK_BIT >= HB_COUNT_WIDTH) begin : g_chk_blink
        $error("FAIL_BLINK_BIT must be < HB_COUNT_WIDTH");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Reset synchroniser: asserts asynchronously, releases on the 2nd edge.
    // ------------------------------------------------------------------
    logic rst_meta_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q  <= 1'b0;
            rst_sync_no <= 1'b0;
        end else begin
            rst_meta_q  <= 1'b1;
            rst_sync_no <= rst_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat counter (free running, wraps).
    // ------------------------------------------------------------------
    logic [HB_COUNT_WIDTH-1:0] hb_cnt_q;

    always_ff @(posedge clk_gen or negedge rst_sync_no) begin
        if (!rst_sync_no) hb_cnt_q <= '0;
        else              hb_cnt_q <= hb_cnt_q + HB_COUNT_WIDTH'(1);
    end

    // ------------------------------------------------------------------
    // Input synchronisers.
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] in_meta_q;
    logic [NUM_INPUTS-1:0] in_sync_q;

    always_ff @(posedge clk_gen or negedge rst_sync_no) begin
        if (!rst_sync_no) begin
            in_meta_q <= '0;
            in_sync_q <= '0;
        end else begin
            in_meta_q <= raw_in_i;
            in_sync_q <= in_meta_q;
        end
    end

`ifdef XHEEP_STATUS_DEBOUNCE_EN
    // Each channel counts consecutive cycles of disagreement with its output.
    // The toggle happens on the cycle the count would reach DEBOUNCE_CYCLES,
    // so a stable change lands 2 + DEBOUNCE_CYCLES cycles after the pin.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk_gen or negedge rst_sync_no) begin
            if (!rst_sync_no) begin
                cnt_q          <= '0;
                debounced_o[i] <= 1'b0;
            end else if (in_sync_q[i] == debounced_o[i]) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q          <= '0;
                debounced_o[i] <= ~debounced_o[i];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    assign debounced_o = in_sync_q;
`endif

    // ------------------------------------------------------------------
    // Exit FSM: first exit wins, clear_i returns to RUN.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_e;

    state_e state_q;
    logic   exit_prev_q;
    logic   exit_edge;

    // exit_prev_q resets low, so a level already high at release is an edge.
    assign exit_edge = exit_valid_i & ~exit_prev_q;

    always_ff @(posedge clk_gen or negedge rst_sync_no) begin
        if (!rst_sync_no) begin
            state_q        <= RUN;
            exit_prev_q    <= 1'b0;
            exit_latched_o <= 1'b0;
            exit_code_o    <= '0;
        end else begin
            // Always tracks the input, so an edge coincident with clear_i
            // is consumed rather than deferred.
            exit_prev_q <= exit_valid_i;
            if (clear_i) begin
                state_q        <= RUN;
                exit_latched_o <= 1'b0;
                exit_code_o    <= '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (exit_edge) begin
                            exit_latched_o <= 1'b1;
                            exit_code_o    <= exit_value_i;
                            state_q        <= (exit_value_i == 32'd0) ? PASS : FAIL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // LED map.
    // ------------------------------------------------------------------
    logic [NUM_LEDS-1:0] run_led;

    assign run_led[0] = hb_cnt_q[HB_COUNT_WIDTH-1];
    assign run_led[1] = rst_sync_no;

    for (genvar k = 2; k < NUM_LEDS; k++) begin : g_led
        if (k - 2 < NUM_INPUTS) begin : g_in
            assign run_led[k] = debounced_o[k-2];
        end else begin : g_off
            assign run_led[k] = 1'b0;
        end
    end

    always_comb begin
        led_o = run_led;
        case (state_q)
            PASS:    led_o = '1;
            FAIL:    led_o = {NUM_LEDS{hb_cnt_q[FAIL_BLINK_BIT]}};
            default: led_o = run_led;
        endcase
    end

endmodule

// File: tb/tb_xheep_fpga_status_ctrl.sv
// Self-checking bench for xheep_fpga_status_ctrl (small heartbeat counter,
// DEBOUNCE_CYCLES=10). A behavioural model runs alongside the DUT and every
// output is compared on each falling edge; directed tables and sequences
// cover reset release, debounce, exit capture and clear priority, followed
// by a randomized phase.

module tb_xheep_fpga_status_ctrl;

    localparam int NL  = 4;
    localparam int NI  = 2;
    localparam int HBW = 4;
    localparam int FBB = 2;
    localparam int DC  = 10;
`ifdef XHEEP_STATUS_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 2 + DC;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 2;
`endif

    logic          clk_gen = 1'b0;
    logic          rst_n   = 1'b1;
    logic          rst_sync_no;
    logic [NI-1:0] raw_in_i = '0;
    logic [NI-1:0] debounced_o;
    logic          exit_valid_i = 1'b0;
    logic [31:0]   exit_value_i = '0;
    logic          clear_i = 1'b0;
    logic          exit_latched_o;
    logic [31:0]   exit_code_o;
    logic [NL-1:0] led_o;

    xheep_fpga_status_ctrl #(
        .NUM_LEDS       (NL),
        .NUM_INPUTS     (NI),
        .HB_COUNT_WIDTH (HBW),
        .FAIL_BLINK_BIT (FBB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_gen       (clk_gen),
        .rst_n         (rst_n),
        .rst_sync_no   (rst_sync_no),
        .raw_in_i      (raw_in_i),
        .debounced_o   (debounced_o),
        .exit_valid_i  (exit_valid_i),
        .exit_value_i  (exit_value_i),
        .clear_i       (clear_i),
        .exit_latched_o(exit_latched_o),
        .exit_code_o   (exit_code_o),
        .led_o         (led_o)
    );

    always #5 clk_gen = ~clk_gen;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    int          m_rs_edges;   // clock edges seen with rst_n high since reset
    bit          m_rsync;
    int unsigned m_hb;         // cycles since reset release, mod 2^HBW
    logic [NI-1:0] m_s1, m_s2, m_deb;
    int          m_run [NI];   // consecutive cycles input disagreed with output
    bit          m_prev, m_lat;
    logic [31:0] m_code;

    task automatic m_async_reset();
        m_rs_edges = 0; m_rsync = 0; m_hb = 0;
        m_s1 = '0; m_s2 = '0; m_deb = '0;
        for (int i = 0; i < NI; i++) m_run[i] = 0;
        m_prev = 0; m_lat = 0; m_code = '0;
    endtask

    task automatic m_edge();
        bit act;
        logic [NI-1:0] old_s2;
        act = m_rsync;
        if (rst_n) begin
            if (m_rs_edges < 2) m_rs_edges++;
        end else begin
            m_rs_edges = 0;
        end
        if (act) begin
            m_hb   = (m_hb + 1) % (1 << HBW);
            old_s2 = m_s2;
            m_s2   = m_s1;
            m_s1   = raw_in_i;
            if (DEB) begin
                for (int i = 0; i < NI; i++) begin
                    if (old_s2[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= DC) begin
                            m_deb[i] = ~m_deb[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end else begin
                m_deb = m_s2;
            end
            if (clear_i) begin
                m_lat = 0; m_code = '0;
            end else if (exit_valid_i && !m_prev && !m_lat) begin
                m_lat = 1; m_code = exit_value_i;
            end
            m_prev = exit_valid_i;
        end else if (!rst_n) begin
            m_async_reset();
        end
        m_rsync = (m_rs_edges >= 2);
    endtask

    function automatic logic [NL-1:0] m_led();
        logic [NL-1:0] l;
        l = '0;
        if (!m_lat) begin
            l[0] = m_hb[HBW-1];
            l[1] = m_rsync;
            for (int k = 2; k < NL; k++)
                if (k - 2 < NI) l[k] = m_deb[k-2];
        end else if (m_code == 32'd0) begin
            l = '1;
        end else begin
            l = {NL{m_hb[FBB]}};
        end
        return l;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rst_sync_no",    32'(rst_sync_no),    32'(m_rsync));
        chk("debounced_o",    32'(debounced_o),    32'(m_deb));
        chk("exit_latched_o", 32'(exit_latched_o), 32'(m_lat));
        chk("exit_code_o",    exit_code_o,         m_code);
        chk("led_o",          32'(led_o),          32'(m_led()));
    endtask

    // One clock: model advances at the rising edge, outputs compared on the
    // falling edge; callers then drive new inputs.
    task automatic step();
        @(posedge clk_gen);
        m_edge();
        @(negedge clk_gen);
        check_all();
    endtask

    task automatic wait_deb(input int ch, input int exp_lat);
        int n;
        n = 0;
        while (debounced_o[ch] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("deb_latency", n, exp_lat);
    endtask

    // ---------------- exit vector table ----------------
    typedef struct {
        logic        ev;
        logic [31:0] val;
        logic        clr;
        logic        exp_lat;
        logic [31:0] exp_code;
    } vec_t;

    vec_t tbl [14];

    task automatic apply_row(input int i);
        exit_valid_i = tbl[i].ev;
        exit_value_i = tbl[i].val;
        clear_i      = tbl[i].clr;
        step();
        chk("tbl_latched", 32'(exit_latched_o), 32'(tbl[i].exp_lat));
        chk("tbl_code",    exit_code_o,         tbl[i].exp_code);
    endtask

    initial begin
        int seen0, seen1;

        tbl[0]  = '{1'b1, 32'd0, 1'b0, 1'b1, 32'd0};   // PASS
        tbl[1]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0};   // clear
        tbl[3]  = '{1'b1, 32'd5, 1'b0, 1'b1, 32'd5};   // FAIL, code 5
        tbl[4]  = '{1'b0, 32'd5, 1'b0, 1'b1, 32'd5};
        tbl[5]  = '{1'b1, 32'd7, 1'b0, 1'b1, 32'd5};   // second edge ignored
        tbl[6]  = '{1'b0, 32'd7, 1'b0, 1'b1, 32'd5};
        tbl[7]  = '{1'b1, 32'd9, 1'b1, 1'b0, 32'd0};   // clear beats edge
        tbl[8]  = '{1'b1, 32'd9, 1'b0, 1'b0, 32'd0};   // held high: no re-latch
        tbl[9]  = '{1'b1, 32'd9, 1'b0, 1'b0, 32'd0};
        tbl[10] = '{1'b0, 32'd9, 1'b0, 1'b0, 32'd0};
        tbl[11] = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd3};   // new edge latches
        tbl[12] = '{1'b0, 32'd3, 1'b1, 1'b0, 32'd0};
        tbl[13] = '{1'b1, 32'd0, 1'b0, 1'b1, 32'd0};   // PASS again

        m_async_reset();

        // Reset release.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("reset_led", 32'(led_o), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_sync_1st_edge", 32'(rst_sync_no), 32'd0);
        step();
        chk("rst_sync_2nd_edge", 32'(rst_sync_no), 32'd1);
        for (int i = 0; i < 7; i++) step();
        chk("hb_led0_before_toggle", 32'(led_o[0]), 32'd0);
        step();
        chk("hb_led0_toggle", 32'(led_o[0]), 32'd1);

        // Short glitch on input 0.
        raw_in_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        raw_in_i[0] = 1'b0;
        for (int i = 0; i < 16; i++) step();
`ifdef XHEEP_STATUS_DEBOUNCE_EN
        chk("glitch_filtered", 32'(debounced_o), 32'd0);
`endif

        // Held levels.
        raw_in_i[0] = 1'b1;
        wait_deb(0, LAT);
        chk("led2_follows_in0", 32'(led_o[2]), 32'd1);
        raw_in_i[1] = 1'b1;
        wait_deb(1, LAT);
        chk("led3_follows_in1", 32'(led_o[3]), 32'd1);

        // Exit pass/fail/clear table with blink check in FAIL.
        for (int i = 0; i <= 4; i++) begin
            apply_row(i);
            if (i == 0) chk("pass_leds", 32'(led_o), 32'hF);
        end
        seen0 = 0; seen1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (led_o == '0) seen0++;
            else if (led_o == '1) seen1++;
        end
        chk("fail_blink_off", seen0, 4);
        chk("fail_blink_on",  seen1, 4);
        for (int i = 5; i < 14; i++) apply_row(i);
        exit_valid_i = 1'b0;

        // Reset in PASS with a debounce count running on input 0.
        raw_in_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        m_async_reset();
        check_all();
        chk("async_rst_led", 32'(led_o), 32'd0);
        chk("async_rst_code", exit_code_o, 32'd0);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        step();
        chk("rerelease_rsync", 32'(rst_sync_no), 32'd1);
        chk("rerelease_run", 32'(exit_latched_o), 32'd0);

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NI; b++)
                if ($urandom_range(0, 15) == 0) raw_in_i[b] = ~raw_in_i[b];
            if ($urandom_range(0, 3) == 0) exit_valid_i = ~exit_valid_i;
            exit_value_i = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            clear_i = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
